// File: rtl/fp_issue_queue_pkg.sv
// Shared structs package for the issue -> FP execution path.
// Holds the packet type that issue hands to the FP ALU and the FP issue
// queue depth, so the issue logic and the queue agree on both.
package fp_issue_queue_pkg;

  // Entry count of the FP issue queue (power of two, at least 2)
  localparam int unsigned FP_IQ_DEPTH = 4;

  typedef enum logic [2:0] {
    FP_ADD = 3'd0,
    FP_SUB = 3'd1,
    FP_MUL = 3'd2,
    FP_FMA = 3'd3,
    FP_CMP = 3'd4,
    FP_CVT = 3'd5
  } fp_op_e;

  typedef struct packed {
    logic [7:0]  ticket;  // in-order tag assigned by issue
    fp_op_e      op;
    logic [4:0]  rd;
    logic [2:0]  rm;      // rounding mode
    logic [31:0] src_a;
    logic [31:0] src_b;
  } to_execution;

endpackage

// File: rtl/fp_issue_queue.sv
// fp_issue_queue: in-order FIFO between the issue stage and the FP ALU.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   flush      in   drop every queued entry (redirect)
//   in_valid   in   issue presents in_data
//   in_data    in   to_execution packet from issue
//   in_ready   out  queue has room (not full)
//   busy_fu    in   FP ALU cannot take the head this cycle
//   fu_valid   out  head entry offered to the FP ALU
//   fu_data    out  head entry
//   occupancy  out  number of valid entries, 0..DEPTH
//   stall_cnt  out  saturating count of cycles with fu_valid && busy_fu
module fp_issue_queue
  import fp_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = FP_IQ_DEPTH,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  to_execution                in_data,
  output logic                       in_ready,
  input  logic                       busy_fu,
  output logic                       fu_valid,
  output to_execution                fu_data,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_BITS-1:0]        stall_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  to_execution         mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CNT_BITS-1:0] stall_q, stall_d;

  logic push, pop;

  // No bypass in either direction: both flags come straight from count_q,
  // keeping in_valid off the fu_valid path.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign fu_valid  = (count_q != '0);
  assign fu_data   = mem_q[rd_ptr_q];
  assign occupancy = count_q;
  assign stall_cnt = stall_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = fu_valid && !busy_fu && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // Counts through flush cycles too; sticks at all-ones
    if (fu_valid && busy_fu && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Storage is intentionally not reset; fu_data is only meaningful with fu_valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_fp_issue_queue.sv
// Self-checking bench for fp_issue_queue: a queue-based reference model,
// a per-cycle compare process, and literal checks for the directed cases.
module tb_fp_issue_queue;
  import fp_issue_queue_pkg::*;

  localparam int DEPTH    = FP_IQ_DEPTH;
  localparam int CNT_BITS = 16;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam longint SMAX = (64'd1 << CNT_BITS) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  to_execution         in_data = '0;
  logic                in_ready;
  logic                busy_fu = 1'b0;
  logic                fu_valid;
  to_execution         fu_data;
  logic [CW-1:0]       occupancy;
  logic [CNT_BITS-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  fp_issue_queue #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy_fu(busy_fu), .fu_valid(fu_valid), .fu_data(fu_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  to_execution m_q[$];
  longint      m_stall = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_stall = 0;
      end else begin
        automatic bit full = (m_q.size() == DEPTH);
        automatic bit vld  = (m_q.size() != 0);
        if (vld && busy_fu && m_stall < SMAX) m_stall++;
        if (flush) begin
          m_q.delete();
        end else begin
          if (vld && !busy_fu) void'(m_q.pop_front());
          if (in_valid && !full) m_q.push_back(in_data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready",  128'(in_ready),  128'(m_q.size() != DEPTH));
      chk("fu_valid",  128'(fu_valid),  128'(m_q.size() != 0));
      chk("occupancy", 128'(occupancy), 128'(m_q.size()));
      chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
      if (m_q.size() != 0) chk("fu_data", 128'(fu_data), 128'(m_q[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic to_execution mk(input logic [7:0] t);
    to_execution p;
    p.ticket = t;
    p.op     = fp_op_e'($urandom_range(0, 5));
    p.rd     = 5'($urandom);
    p.rm     = 3'($urandom);
    p.src_a  = $urandom;
    p.src_b  = $urandom;
    return p;
  endfunction

  task automatic push_one(input logic [7:0] t);
    in_valid = 1'b1;
    in_data  = mk(t);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] tk;
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_fu_valid", 128'(fu_valid), 128'(0));
    chk("rst_occ",      128'(occupancy), 128'(0));
    chk("rst_stall",    128'(stall_cnt), 128'(0));

    // Fill with busy FU: tickets 1..4
    busy_fu = 1'b1;
    for (int i = 1; i <= 4; i++) push_one(8'(i));
    chk("fill_occ",    128'(occupancy), 128'(4));
    chk("fill_ready",  128'(in_ready), 128'(0));
    chk("fill_head",   128'(fu_data.ticket), 128'(1));
    chk("fill_stall",  128'(stall_cnt), 128'(3));

    // Drain in order
    busy_fu = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_ticket", 128'(fu_data.ticket), 128'(i));
      step();
    end
    chk("drain_valid", 128'(fu_valid), 128'(0));
    chk("drain_occ",   128'(occupancy), 128'(0));
    chk("drain_stall", 128'(stall_cnt), 128'(3));

    // Full with simultaneous pop: 4 -> 3 -> 4
    busy_fu = 1'b1;
    for (int i = 5; i <= 8; i++) push_one(8'(i));
    busy_fu  = 1'b0;
    in_valid = 1'b1;
    in_data  = mk(8'd9);
    step();
    chk("fullpop_occ3", 128'(occupancy), 128'(3));
    busy_fu = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fullpop_occ4", 128'(occupancy), 128'(4));
    chk("fullpop_head", 128'(fu_data.ticket), 128'(6));

    // Flush collision with 3 entries
    busy_fu = 1'b0;
    repeat (4) step();
    busy_fu = 1'b1;
    for (int i = 20; i <= 22; i++) push_one(8'(i));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = mk(8'd23);
    busy_fu  = 1'b0;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ",   128'(occupancy), 128'(0));
    chk("flush_valid", 128'(fu_valid), 128'(0));
    busy_fu = 1'b1;
    push_one(8'd24);
    chk("post_flush_head", 128'(fu_data.ticket), 128'(24));
    chk("post_flush_occ",  128'(occupancy), 128'(1));
    busy_fu = 1'b0;
    step();

    // Randomised traffic
    tk = 8'd100;
    for (int c = 0; c < 1500; c++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = mk(tk);
        tk++;
      end
      busy_fu = ($urandom_range(0, 2) == 0);
      flush   = ($urandom_range(0, 31) == 0);
      step();
    end
    flush    = 1'b0;
    in_valid = 1'b0;

    // Async reset mid-stream with 2 entries
    busy_fu = 1'b0;
    repeat (5) step();
    busy_fu = 1'b1;
    push_one(8'd50);
    push_one(8'd51);
    chk("pre_arst_occ", 128'(occupancy), 128'(2));
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(fu_valid), 128'(0));
    chk("arst_occ",   128'(occupancy), 128'(0));
    chk("arst_ready", 128'(in_ready), 128'(1));
    chk("arst_stall", 128'(stall_cnt), 128'(0));
    step();
    rst = 1'b0;

    // Stall counter saturation
    busy_fu = 1'b1;
    push_one(8'd60);
    repeat ((1 << CNT_BITS) + 5) step();
    chk("sat_stall", 128'(stall_cnt), 128'(16'hFFFF));
    repeat (5) step();
    chk("sat_hold",  128'(stall_cnt), 128'(16'hFFFF));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sat_flush_keep", 128'(stall_cnt), 128'(16'hFFFF));
    #2 rst = 1'b1;
    #1;
    chk("sat_rst_clear", 128'(stall_cnt), 128'(0));
    step();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
